// File: rtl/bus_dvc_endpoint.sv
// Device-side endpoint for the bus generator/arbiter protocol.
// TX: local writes are queued and presented to the bus as pndng/D_pop, drained by pop.
// RX: bus deliveries addressed to this device (or broadcast) are queued for local reads;
//     deliveries for other devices are counted and discarded.
module bus_dvc_endpoint #(
   parameter int         pckg_sz   = 16,
   parameter int         depth     = 8,
   parameter logic [7:0] id        = 8'h00,
   parameter logic [7:0] broadcast = 8'hFF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tx_wr,
   input  logic [pckg_sz-1:0] tx_data,
   output logic               tx_full,
   output logic               pndng,
   output logic [pckg_sz-1:0] D_pop,
   input  logic               pop,
   input  logic               push,
   input  logic [pckg_sz-1:0] D_push,
   input  logic               rx_rd,
   output logic [pckg_sz-1:0] rx_data,
   output logic               rx_valid,
   output logic               tx_ovf,
   output logic               tx_unf,
   output logic               rx_ovf,
   output logic [7:0]         rx_drop_cnt
);

   localparam int              aw       = $clog2(depth);
   localparam int              cw       = aw + 1;
   localparam logic [cw-1:0]   full_cnt = cw'(depth);

   // TX FIFO state
   logic [pckg_sz-1:0] tx_mem_q [depth];
   logic [aw-1:0]      tx_wr_ptr_q, tx_wr_ptr_d;
   logic [aw-1:0]      tx_rd_ptr_q, tx_rd_ptr_d;
   logic [cw-1:0]      tx_cnt_q, tx_cnt_d;
   logic               tx_ovf_q, tx_ovf_d;
   logic               tx_unf_q, tx_unf_d;

   // RX FIFO state
   logic [pckg_sz-1:0] rx_mem_q [depth];
   logic [aw-1:0]      rx_wr_ptr_q, rx_wr_ptr_d;
   logic [aw-1:0]      rx_rd_ptr_q, rx_rd_ptr_d;
   logic [cw-1:0]      rx_cnt_q, rx_cnt_d;
   logic               rx_ovf_q, rx_ovf_d;
   logic [7:0]         rx_drop_cnt_q, rx_drop_cnt_d;

   // Status decodes depend only on registered counts
   logic tx_empty, tx_is_full, tx_do_wr, tx_do_rd;
   logic rx_empty, rx_is_full, rx_do_wr, rx_do_rd, rx_accept;

   assign tx_empty   = (tx_cnt_q == '0);
   assign tx_is_full = (tx_cnt_q == full_cnt);
   assign rx_empty   = (rx_cnt_q == '0);
   assign rx_is_full = (rx_cnt_q == full_cnt);

   // A full FIFO is never empty, so a same-cycle read always frees the slot being written.
   assign tx_do_rd  = pop && !tx_empty;
   assign tx_do_wr  = tx_wr && (!tx_is_full || pop);
   assign rx_accept = (D_push[pckg_sz-1 -: 8] == id) || (D_push[pckg_sz-1 -: 8] == broadcast);
   assign rx_do_rd  = rx_rd && !rx_empty;
   assign rx_do_wr  = push && rx_accept && (!rx_is_full || rx_rd);

   // Next-state for TX pointers, occupancy and sticky error flags
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      tx_wr_ptr_d = tx_wr_ptr_q;
      tx_rd_ptr_d = tx_rd_ptr_q;
      tx_ovf_d    = tx_ovf_q;
      tx_unf_d    = tx_unf_q;
      if (tx_do_wr) tx_wr_ptr_d = tx_wr_ptr_q + 1'b1;
      if (tx_do_rd) tx_rd_ptr_d = tx_rd_ptr_q + 1'b1;
      tx_cnt_d = tx_cnt_q + cw'(tx_do_wr) - cw'(tx_do_rd);
      if (tx_wr && tx_is_full && !pop) tx_ovf_d = 1'b1;
      if (pop && tx_empty)             tx_unf_d = 1'b1;
   end

   // Next-state for RX pointers, occupancy, overflow flag and filter-reject counter
   always_comb begin
      rx_wr_ptr_d   = rx_wr_ptr_q;
      rx_rd_ptr_d   = rx_rd_ptr_q;
      rx_ovf_d      = rx_ovf_q;
      rx_drop_cnt_d = rx_drop_cnt_q;
      if (rx_do_wr) rx_wr_ptr_d = rx_wr_ptr_q + 1'b1;
      if (rx_do_rd) rx_rd_ptr_d = rx_rd_ptr_q + 1'b1;
      rx_cnt_d = rx_cnt_q + cw'(rx_do_wr) - cw'(rx_do_rd);
      if (push && rx_accept && rx_is_full && !rx_rd) rx_ovf_d = 1'b1;
      if (push && !rx_accept && (rx_drop_cnt_q != 8'hFF))
         rx_drop_cnt_d = rx_drop_cnt_q + 8'd1;
   end

   // Control/status registers; reset discards all queued packets at once
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_wr_ptr_q   <= '0;
         tx_rd_ptr_q   <= '0;
         tx_cnt_q      <= '0;
         tx_ovf_q      <= 1'b0;
         tx_unf_q      <= 1'b0;
         rx_wr_ptr_q   <= '0;
         rx_rd_ptr_q   <= '0;
         rx_cnt_q      <= '0;
         rx_ovf_q      <= 1'b0;
         rx_drop_cnt_q <= '0;
      end else begin
         tx_wr_ptr_q   <= tx_wr_ptr_d;
         tx_rd_ptr_q   <= tx_rd_ptr_d;
         tx_cnt_q      <= tx_cnt_d;
         tx_ovf_q      <= tx_ovf_d;
         tx_unf_q      <= tx_unf_d;
         rx_wr_ptr_q   <= rx_wr_ptr_d;
         rx_rd_ptr_q   <= rx_rd_ptr_d;
         rx_cnt_q      <= rx_cnt_d;
         rx_ovf_q      <= rx_ovf_d;
         rx_drop_cnt_q <= rx_drop_cnt_d;
      end
   end

   // Packet storage for both FIFOs
   // NOTE: storage arrays are not reset; zeroed counts keep stale entries invisible.
   always_ff @(posedge clk) begin
      if (tx_do_wr) tx_mem_q[tx_wr_ptr_q] <= tx_data;
      if (rx_do_wr) rx_mem_q[rx_wr_ptr_q] <= D_push;
   end

   assign pndng       = !tx_empty;
   assign tx_full     = tx_is_full;
   assign D_pop       = tx_empty ? '0 : tx_mem_q[tx_rd_ptr_q];
   assign rx_valid    = !rx_empty;
   assign rx_data     = rx_empty ? '0 : rx_mem_q[rx_rd_ptr_q];
   assign tx_ovf      = tx_ovf_q;
   assign tx_unf      = tx_unf_q;
   assign rx_ovf      = rx_ovf_q;
   assign rx_drop_cnt = rx_drop_cnt_q;

endmodule

// File: tb/tb_bus_dvc_endpoint.sv
// Bench for bus_dvc_endpoint (id = 8'h02): directed stimulus pushes expected packets into
// per-direction queues; a negedge monitor pops and compares whenever a FIFO head is consumed.
module tb_bus_dvc_endpoint;

   logic        clk = 1'b0;
   logic        reset;
   logic        tx_wr, pop, push, rx_rd;
   logic [15:0] tx_data, D_push;
   logic        tx_full, pndng, rx_valid, tx_ovf, tx_unf, rx_ovf;
   logic [15:0] D_pop, rx_data;
   logic [7:0]  rx_drop_cnt;

   int vectors     = 0;
   int miscompares = 0;

   logic [15:0] tx_exp[$];
   logic [15:0] rx_exp[$];

   bus_dvc_endpoint #(
      .pckg_sz(16), .depth(8), .id(8'h02), .broadcast(8'hFF)
   ) dut (
      .clk(clk), .reset(reset),
      .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
      .pndng(pndng), .D_pop(D_pop), .pop(pop),
      .push(push), .D_push(D_push),
      .rx_rd(rx_rd), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_ovf(tx_ovf), .tx_unf(tx_unf), .rx_ovf(rx_ovf),
      .rx_drop_cnt(rx_drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: a consumed head must match the oldest expected packet
   always @(negedge clk) begin
      if (!reset && pop && pndng) begin
         if (tx_exp.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL tx_unexpected_pop: got D_pop=%h, expected no pending entry", D_pop);
         end else
            check("tx_pop_data", D_pop, tx_exp.pop_front());
      end
      if (!reset && rx_rd && rx_valid) begin
         if (rx_exp.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL rx_unexpected_read: got rx_data=%h, expected no entry", rx_data);
         end else
            check("rx_read_data", rx_data, rx_exp.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time expired, expected completion");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; tx_wr = 0; pop = 0; push = 0; rx_rd = 0;
      tx_data = '0; D_push = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_pndng", pndng, 0);
      check("rst_d_pop", D_pop, 0);
      reset = 1'b0;
      #1;
      check("init_tx_full", tx_full, 0);
      check("init_rx_valid", rx_valid, 0);
      check("init_rx_data", rx_data, 0);
      check("init_flags", {tx_ovf, tx_unf, rx_ovf}, 0);
      check("init_drop_cnt", rx_drop_cnt, 0);

      // TX basic: three writes, then three pops
      tx_exp.push_back(16'h0311); tx_exp.push_back(16'h0422); tx_exp.push_back(16'hFF33);
      tx_wr = 1; tx_data = 16'h0311; step();
      check("tx_first_pndng", pndng, 1);
      check("tx_first_d_pop", D_pop, 16'h0311);
      tx_data = 16'h0422; step();
      tx_data = 16'hFF33; step();
      tx_wr = 0;
      pop = 1;
      repeat (3) step();
      pop = 0;
      check("tx_drained_pndng", pndng, 0);
      check("tx_drained_d_pop", D_pop, 0);
      check("tx_unf_clear", tx_unf, 0);

      // TX fill to full, overflow, simultaneous write+pop while full
      for (int i = 0; i < 9; i++) begin
         tx_wr = 1; tx_data = 16'h0100 + 16'(i);
         if (i < 8) tx_exp.push_back(tx_data);
         step();
         if (i == 7) begin
            check("tx_full_after_8", tx_full, 1);
            check("tx_ovf_not_yet", tx_ovf, 0);
         end
      end
      tx_wr = 0;
      check("tx_ovf_set", tx_ovf, 1);
      check("tx_full_held", tx_full, 1);
      tx_wr = 1; tx_data = 16'h0109; pop = 1; tx_exp.push_back(16'h0109);
      step();
      tx_wr = 0;
      check("tx_full_wr_pop", tx_full, 1);
      check("tx_head_advance", D_pop, 16'h0101);
      repeat (8) step();
      check("tx_empty_again", pndng, 0);
      check("tx_unf_still_clear", tx_unf, 0);
      step();                               // pop on empty FIFO
      pop = 0;
      check("tx_unf_set", tx_unf, 1);
      check("tx_unf_d_pop", D_pop, 0);

      // RX filter: own ID, other ID, broadcast
      push = 1; D_push = 16'h02AB; rx_exp.push_back(16'h02AB); step();
      check("rx_first_valid", rx_valid, 1);
      check("rx_first_data", rx_data, 16'h02AB);
      D_push = 16'h03CD; step();
      D_push = 16'hFFEE; rx_exp.push_back(16'hFFEE); step();
      push = 0;
      check("rx_drop_one", rx_drop_cnt, 1);
      rx_rd = 1;
      repeat (2) step();
      check("rx_drained", rx_valid, 0);
      step();                               // read on empty FIFO
      rx_rd = 0;
      check("rx_empty_rd_ovf", rx_ovf, 0);
      check("rx_empty_rd_data", rx_data, 0);

      // RX fill, overflow, push+read while full
      for (int i = 0; i < 8; i++) begin
         push = 1; D_push = 16'h0200 + 16'(i); rx_exp.push_back(D_push);
         step();
      end
      D_push = 16'h0299; step();
      push = 0;
      check("rx_ovf_set", rx_ovf, 1);
      check("rx_ovf_no_drop", rx_drop_cnt, 1);
      check("rx_head_unchanged", rx_data, 16'h0200);
      push = 1; D_push = 16'h029A; rx_rd = 1; rx_exp.push_back(16'h029A);
      step();
      push = 0;
      check("rx_head_after_swap", rx_data, 16'h0201);
      repeat (8) step();
      rx_rd = 0;
      check("rx_drained_full", rx_valid, 0);

      // Filter-reject counter saturation
      push = 1;
      for (int i = 0; i < 300; i++) begin
         D_push = {8'h05, 8'(i)};
         step();
         if (i == 252) check("drop_cnt_254", rx_drop_cnt, 8'hFE);
      end
      push = 0;
      check("drop_cnt_sat", rx_drop_cnt, 8'hFF);
      check("drop_no_valid", rx_valid, 0);

      // Asynchronous reset mid-cycle with traffic queued
      for (int i = 0; i < 3; i++) begin
         tx_wr = 1; tx_data = 16'h0A00 + 16'(i);
         push = 1;  D_push  = 16'h0250 + 16'(i);
         step();
      end
      tx_wr = 0; push = 0;
      check("pre_rst_pndng", pndng, 1);
      check("pre_rst_rx_valid", rx_valid, 1);
      #1 reset = 1'b1;
      #1;
      check("arst_pndng", pndng, 0);
      check("arst_rx_valid", rx_valid, 0);
      check("arst_d_pop", D_pop, 0);
      check("arst_rx_data", rx_data, 0);
      check("arst_flags", {tx_full, tx_ovf, tx_unf, rx_ovf}, 0);
      check("arst_drop_cnt", rx_drop_cnt, 0);
      #1 reset = 1'b0;
      #1;
      check("post_rst_pndng", pndng, 0);
      step();

      // Write and pop together on an empty FIFO: write lands, pop flags underflow
      tx_wr = 1; tx_data = 16'h0177; pop = 1; tx_exp.push_back(16'h0177);
      step();
      tx_wr = 0; pop = 0;
      check("post_rst_wr_pndng", pndng, 1);
      check("post_rst_wr_d_pop", D_pop, 16'h0177);
      check("post_rst_unf", tx_unf, 1);
      pop = 1; step(); pop = 0;
      check("post_rst_no_stale", pndng, 0);
      check("post_rst_no_stale_data", D_pop, 0);
      check("post_rst_rx_valid", rx_valid, 0);

      check("tx_scoreboard_empty", tx_exp.size(), 0);
      check("rx_scoreboard_empty", rx_exp.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
